// File: rtl/ring_johnson_counter_n.sv
// N-bit ring / Johnson shift counter with load, illegal-state
// detection, optional self-correction and a wrap counter.
module ring_johnson_counter_n #(
  parameter int N            = 4,
  parameter int CNT_W        = 8,
  parameter bit SELF_CORRECT = 1'b1
) (
  input  logic             CLK,
  input  logic             OverRide_IN,
  input  logic             EN,
  input  logic             MODE,
  input  logic             DIR,
  input  logic             LOAD,
  input  logic [N-1:0]     LOAD_VAL,
  output logic [N-1:0]     Q,
  output logic             TC,
  output logic             ERR,
  output logic [CNT_W-1:0] WRAP_CNT
);

  logic [N-1:0] start_pat;
  logic [N-1:0] shift_q;
  logic [N-2:0] edges;
  logic         fix;
  logic         wrap_hit;

  always_comb begin
    start_pat = '0;
    if (!MODE) start_pat[0] = 1'b1;
  end

  // a Johnson code has at most one boundary between adjacent bits
  assign edges = Q[N-2:0] ^ Q[N-1:1];

  always_comb begin
    if (MODE) ERR = ($countones(edges) > 1);
    else      ERR = ($countones(Q) != 1);
  end

  always_comb begin
    shift_q = Q;
    unique case ({MODE, DIR})
      2'b00: shift_q = {Q[N-2:0], Q[N-1]};
      2'b01: shift_q = {Q[0], Q[N-1:1]};
      2'b10: shift_q = {Q[N-2:0], ~Q[N-1]};
      2'b11: shift_q = {~Q[0], Q[N-1:1]};
    endcase
  end

  assign fix      = EN & ERR & SELF_CORRECT;
  assign wrap_hit = EN & ~fix & (shift_q == start_pat);

  always_ff @(negedge CLK) begin
    if (!OverRide_IN) begin
      Q        <= start_pat;
      TC       <= 1'b0;
      WRAP_CNT <= '0;
    end else if (LOAD) begin
      Q        <= LOAD_VAL;
      TC       <= 1'b0;
      WRAP_CNT <= '0;
    end else if (fix) begin
      Q  <= start_pat;
      TC <= 1'b0;
    end else if (EN) begin
      Q  <= shift_q;
      TC <= wrap_hit;
      if (wrap_hit) WRAP_CNT <= WRAP_CNT + CNT_W'(1);
    end else begin
      TC <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ring_johnson_counter_n.sv
// Scoreboard bench for ring_johnson_counter_n, N=4, with and
// without self-correction.
module tb_ring_johnson_counter_n;

  localparam int N = 4;
  localparam int W = 8;

  logic         clk = 1'b1;
  logic         rst_n, en, mode, dir, load;
  logic [N-1:0] load_val;
  logic [N-1:0] q, nq;
  logic         tc, ntc, err, nerr;
  logic [W-1:0] wrap, nwrap;

  typedef struct {
    logic [N-1:0] q;
    logic         tc;
    logic [W-1:0] w;
    logic         err;
    logic [N-1:0] nq;
    logic         ntc;
    logic         nerr;
  } exp_t;

  exp_t sb[$];

  logic [N-1:0] mq, mnq;
  logic         mtc, mntc;
  logic [W-1:0] mw, mnw;

  int n_chk  = 0;
  int n_fail = 0;

  ring_johnson_counter_n #(.N(N), .CNT_W(W), .SELF_CORRECT(1'b1)) dut (
    .CLK(clk), .OverRide_IN(rst_n), .EN(en), .MODE(mode),
    .DIR(dir), .LOAD(load), .LOAD_VAL(load_val),
    .Q(q), .TC(tc), .ERR(err), .WRAP_CNT(wrap)
  );

  ring_johnson_counter_n #(.N(N), .CNT_W(W), .SELF_CORRECT(1'b0)) dut_nc (
    .CLK(clk), .OverRide_IN(rst_n), .EN(en), .MODE(mode),
    .DIR(dir), .LOAD(load), .LOAD_VAL(load_val),
    .Q(nq), .TC(ntc), .ERR(nerr), .WRAP_CNT(nwrap)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [N-1:0] start_of(input logic md);
    return md ? '0 : N'(1);
  endfunction

  function automatic logic legal(input logic [N-1:0] v,
                                 input logic md);
    int ones;
    logic [N-1:0] th;
    if (!md) begin
      ones = 0;
      for (int i = 0; i < N; i++) ones += int'(v[i]);
      return ones == 1;
    end
    for (int k = 0; k <= N; k++) begin
      th = '0;
      for (int i = 0; i < k; i++) th[i] = 1'b1;
      if (v == th || v == ~th) return 1'b1;
    end
    return 1'b0;
  endfunction

  function automatic logic [N-1:0] shifted(input logic [N-1:0] v,
                                           input logic md,
                                           input logic dr);
    logic [N-1:0] r;
    if (!dr) begin
      for (int i = 1; i < N; i++) r[i] = v[i-1];
      r[0] = md ? ~v[N-1] : v[N-1];
    end else begin
      for (int i = 0; i < N-1; i++) r[i] = v[i+1];
      r[N-1] = md ? ~v[0] : v[0];
    end
    return r;
  endfunction

  task automatic model(inout logic [N-1:0] s, inout logic t,
                       inout logic [W-1:0] w, input bit sc);
    if (!rst_n) begin
      s = start_of(mode); t = 0; w = 0;
    end else if (load) begin
      s = load_val; t = 0; w = 0;
    end else if (en && sc && !legal(s, mode)) begin
      s = start_of(mode); t = 0;
    end else if (en) begin
      s = shifted(s, mode, dir);
      t = (s == start_of(mode));
      if (t) w = w + 1;
    end else begin
      t = 0;
    end
  endtask

  task automatic step(input logic e, input logic md, input logic dr,
                      input logic ld, input logic [N-1:0] lv,
                      input logic rs);
    exp_t x, y;
    en = e; mode = md; dir = dr; load = ld; load_val = lv; rst_n = rs;
    model(mq, mtc, mw, 1'b1);
    model(mnq, mntc, mnw, 1'b0);
    x.q = mq; x.tc = mtc; x.w = mw; x.err = !legal(mq, md);
    x.nq = mnq; x.ntc = mntc; x.nerr = !legal(mnq, md);
    sb.push_back(x);
    @(negedge clk);
    #1;
    y = sb.pop_front();
    chk("q", q, y.q);
    chk("tc", tc, y.tc);
    chk("wrap", wrap, y.w);
    chk("err", err, y.err);
    chk("nc_q", nq, y.nq);
    chk("nc_tc", ntc, y.ntc);
    chk("nc_err", nerr, y.nerr);
  endtask

  initial begin
    rst_n = 0; en = 0; mode = 0; dir = 0; load = 0; load_val = '0;
    #1;
    // ring, toward MSB
    step(0, 0, 0, 0, 4'h0, 0);
    chk("rst_q", q, 4'b0001);
    chk("rst_wrap", wrap, 0);
    for (int i = 0; i < 5; i++) begin
      step(1, 0, 0, 0, 4'h0, 1);
      if (i == 3) chk("ring_tc4", tc, 1);
    end
    chk("ring_q5", q, 4'b0010);
    chk("ring_wrap", wrap, 1);
    // Johnson
    step(0, 1, 0, 0, 4'h0, 0);
    for (int i = 0; i < 8; i++) step(1, 1, 0, 0, 4'h0, 1);
    chk("john_q8", q, 4'b0000);
    chk("john_tc8", tc, 1);
    step(1, 1, 1, 0, 4'h0, 1);
    chk("john_rev", q, 4'b1000);
    // ring toward LSB, wrap counter rollover
    step(0, 0, 1, 0, 4'h0, 0);
    for (int i = 0; i < 4 * 255; i++) step(1, 0, 1, 0, 4'h0, 1);
    chk("wrap_255", wrap, 255);
    for (int i = 0; i < 4; i++) step(1, 0, 1, 0, 4'h0, 1);
    chk("wrap_roll", wrap, 0);
    chk("wrap_tc", tc, 1);
    // illegal load
    step(0, 0, 0, 1, 4'b0101, 1);
    chk("ld_err", err, 1);
    step(1, 0, 0, 0, 4'h0, 1);
    chk("fix_q", q, 4'b0001);
    chk("nofix_q", nq, 4'b1010);
    chk("nofix_err", nerr, 1);
    // mode switch makes state illegal
    step(0, 0, 0, 0, 4'h0, 0);
    step(1, 0, 0, 0, 4'h0, 1);
    step(1, 0, 0, 0, 4'h0, 1);
    mode = 1;
    #1;
    chk("mode_err_now", err, !legal(mq, 1'b1));
    chk("mode_err_lit", err, 1);
    step(0, 1, 0, 0, 4'h0, 1);
    chk("hold_q", q, 4'b0100);
    step(1, 1, 0, 0, 4'h0, 1);
    chk("mode_fix_q", q, 4'b0000);
    chk("mode_fix_tc", tc, 0);
    // reset beats load and enable
    step(0, 0, 0, 0, 4'h0, 0);
    for (int i = 0; i < 6; i++) step(1, 0, 0, 0, 4'h0, 1);
    step(1, 0, 0, 1, 4'hF, 0);
    chk("rst_pri_q", q, 4'b0001);
    chk("rst_pri_wrap", wrap, 0);
    step(1, 0, 0, 0, 4'h0, 1);
    chk("resume_q", q, 4'b0010);
    // random mix
    for (int i = 0; i < 300; i++)
      step(1'($urandom_range(0, 3) != 0), 1'($urandom),
           1'($urandom), 1'($urandom_range(0, 15) == 0),
           4'($urandom), 1'($urandom_range(0, 31) != 0));
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/ring_johnson_counter_n.md
Name: ring_johnson_counter_n

Overview:
Parametrised N-bit shift-register counter and successor to the fixed 4-bit ring counter. It runs in ring mode (one-hot, period N) or Johnson/twisted-ring mode (period 2N). It supports selectable direction, count enable, parallel load, illegal-state detection with optional self-correction, a terminal-count pulse and a wrap counter. It is used as a sequencer or phase generator wherever a one-hot or thermometer phase sequence is needed.

Parameters:
N, 4, counter width in bits; legal range N >= 2.
CNT_W, 8, width of the wrap counter.
SELF_CORRECT, 1, 1 = an illegal state is replaced by the start pattern on the next enabled edge; 0 = an illegal state shifts as-is.

Ports:
CLK  input  1  clock; all state updates on the falling edge of CLK
OverRide_IN  input  1  synchronous active-low reset, sampled on the falling edge of CLK
EN  input  1  count enable
MODE  input  1  0 = ring, 1 = Johnson
DIR  input  1  0 = shift toward MSB (Q[i] takes Q[i-1]), 1 = shift toward LSB
LOAD  input  1  parallel load strobe
LOAD_VAL  input  N  value loaded into Q
Q  output  N  counter state, registered
TC  output  1  terminal-count pulse, registered
ERR  output  1  combinational; high while Q is illegal for the current MODE
WRAP_CNT  output  CNT_W  number of TC events, registered

Behaviour:
- Start pattern S(MODE): ring = 1 in bit 0, 0 elsewhere (0...01); Johnson = all zeros.
- Update priority on each falling edge: reset > LOAD > correction > shift > hold.
- Reset (OverRide_IN==0): Q <= S(MODE); TC <= 0; WRAP_CNT <= 0. This overrides EN, LOAD and MODE changes in the same cycle.
- LOAD==1: Q <= LOAD_VAL, independent of EN. No legality check is applied, which allows fault injection. TC <= 0; WRAP_CNT <= 0.
- Legality:
  - ring: exactly one bit of Q set.
  - Johnson: at most one index i in 0..N-2 with Q[i] != Q[i+1]. Legal states are therefore low-side thermometer codes (0..0, 0..01, 0..011, ...) and high-side thermometer codes (1..10, 1..100, ...).
  - ERR reflects Q and MODE combinationally.
- Correction: when EN==1, ERR==1 and SELF_CORRECT==1, Q <= S(MODE) and TC <= 0. This is not a wrap, so WRAP_CNT is unchanged.
- Shift (EN==1 and no correction):
  - ring, DIR=0: Q <= {Q[N-2:0], Q[N-1]}
  - ring, DIR=1: Q <= {Q[0], Q[N-1:1]}
  - Johnson, DIR=0: Q <= {Q[N-2:0], ~Q[N-1]}
  - Johnson, DIR=1: Q <= {~Q[0], Q[N-1:1]}
- TC: TC <= 1 exactly when a shift's next Q equals S(MODE), in either direction; otherwise TC <= 0. TC is a one-cycle pulse that follows the wrapping edge. When TC is set, WRAP_CNT <= WRAP_CNT + 1, modulo 2^CNT_W (wraps, no saturation).
- Hold (EN==0 and no LOAD): Q and WRAP_CNT hold; TC <= 0.
- MODE or DIR change: takes effect at the next edge; no pipeline.
  - If Q becomes illegal under the new MODE, ERR rises immediately and correction applies on the next enabled edge.
  - A DIR reversal mid-sequence simply retraces states; TC fires on landing on S(MODE).
- Illegal state with SELF_CORRECT==0: shifts by the normal equations, ERR stays high and TC is never generated (the state never equals S).
- Latency: Q changes at the enabling edge; TC and WRAP_CNT update at the same edge as the wrapping Q update.

Test Plan:
1. N=4, ring, DIR=0, reset released, EN=1 for 5 edges -> Q = 0001, 0010, 0100, 1000, 0001, 0010; TC=1 only after the 4th edge; WRAP_CNT=1; ERR=0 throughout.
2. Johnson, DIR=0, 8 enabled edges from reset -> Q = 0001, 0011, 0111, 1111, 1110, 1100, 1000, 0000; TC=1 after the 8th edge; WRAP_CNT=1. Then switch to DIR=1 for 1 edge -> Q = 1000.
3. Ring, DIR=1 from 0001 -> 1000, 0100, 0010, 0001 with TC after the 4th edge. Run 256 periods with CNT_W=8 -> WRAP_CNT wraps 255 -> 0.
4. LOAD 0101 in ring mode -> Q=0101, ERR=1, WRAP_CNT=0. With SELF_CORRECT=1, the next enabled edge gives Q=0001, TC=0, ERR=0. With SELF_CORRECT=0, the next edge gives Q=1010 and ERR stays 1.
5. Ring Q=0100, switch MODE to Johnson -> ERR=1 immediately. Next enabled edge gives Q=0000 and no TC. With EN=0 instead, Q holds 0100 and ERR stays 1.
6. Mid-sequence, assert OverRide_IN=0 together with LOAD=1, LOAD_VAL=1111, EN=1 -> at the edge Q=S(MODE), TC=0, WRAP_CNT=0. Then deassert -> counting resumes from S.
